// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard/stall controller for the 5-stage MIPS pipeline. It drives the
// enable and flush controls of the PC, IF/ID and ID/EX registers.
//   - Load-use hazard: the load in EX writes a register that the instruction
//     in ID reads. This costs one bubble and clears once the load leaves EX.
//   - HI/LO hazard: an mfhi/mflo in ID while the multi-cycle MDU is busy.
//     A RUN/BUSY FSM with a down-counter tracks the MDU.
//   - Branch-taken flush: branches resolve in ID. While the pipeline is
//     stalled the branch is ignored, because its operands may be stale.
//
// Parameters
//   MDU_LATENCY : cycles from MDU start until HI/LO are valid (2..63)
//   CNT_W       : MDU counter width, 2**CNT_W > MDU_LATENCY
//
// Ports
//   clk, rst         : clock; synchronous active-high reset
//   id_rs, id_rt     : source register fields of the instruction in ID
//   id_uses_rt       : instruction in ID reads rt
//   id_uses_hilo     : instruction in ID is mfhi/mflo
//   ex_mem_read      : instruction in EX is a load
//   ex_rt            : load destination register in EX
//   ex_mdu_start     : one-cycle pulse while mult/div is in EX
//   branch_taken_id  : branch/jump in ID resolved taken
//   pc_en            : PC write enable
//   if_id_en         : IF/ID enable (0 = hold)
//   if_id_flush      : IF/ID flush (inserts NOP)
//   id_ex_flush      : ID/EX flush (inserts bubble)
//   mdu_busy         : MDU result not yet valid
//
// Optional feature, enabled by defining HAZARD_CTRL_PERF_EN:
//   perf_stall_cnt   : cycles with a stall
//   perf_flush_cnt   : cycles with a branch-caused IF/ID flush
//   perf_hilo_cnt    : cycles with a HI/LO stall
//   All three clear on rst and wrap modulo 2**32.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_uses_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mdu_start,
  input  logic        branch_taken_id,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mdu_busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_hilo_cnt
`endif
);

  typedef enum logic {RUN, BUSY} state_t;

  // The start cycle itself is not busy, so the counter is loaded with
  // MDU_LATENCY-1. Busy then lasts MDU_LATENCY-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic load_use;
  logic hilo_stall;
  logic stall;
  logic branch_flush;

  // MDU state register. The MDU runs independently of pipeline stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (ex_mdu_start) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (ex_mdu_start) begin
          // A new op supersedes the one in flight.
          cnt_next = CNT_LOAD;
        end else if (cnt_reg == CNT_ONE) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Hazard detection. Register $zero never creates a dependency.
  always_comb begin
    mdu_busy     = (state_reg == BUSY) && !rst;
    load_use     = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    hilo_stall   = id_uses_hilo && mdu_busy;
    stall        = load_use || hilo_stall;
    branch_flush = !rst && !stall && branch_taken_id;
  end

  // Pipeline controls. Priority is rst > stall > branch flush > normal.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (branch_taken_id) begin
      if_id_flush = 1'b1;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_reg, perf_flush_reg, perf_hilo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
      perf_hilo_reg  <= '0;
    end else begin
      if (stall)        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (branch_flush) perf_flush_reg <= perf_flush_reg + 32'd1;
      if (hilo_stall)   perf_hilo_reg  <= perf_hilo_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;
  assign perf_hilo_cnt  = perf_hilo_reg;
`else
  // Without the counters, branch_flush only documents the flush condition.
  logic unused_ok;
  assign unused_ok = branch_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl, built with MDU_LATENCY=4. Directed
// cases come first, followed by randomized cycles. The reference model tracks
// MDU busy from the cycle number of the most recent start. A cycle c is busy
// when last_start < c < last_start + L, and no reset has occurred since.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_uses_hilo, ex_mem_read, ex_mdu_start;
  logic       branch_taken_id;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_hilo_cnt;
  logic [31:0] m_stall_cnt, m_flush_cnt, m_hilo_cnt;
`endif

  hazard_ctrl #(.MDU_LATENCY(L), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_mdu_start(ex_mdu_start), .branch_taken_id(branch_taken_id),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_hilo_cnt(perf_hilo_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = 0;
  bit have_start = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check all outputs mid-cycle against the model,
  // then advance the model across the clock edge.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic uhl, input logic mr,
                      input logic [4:0] ert, input logic st, input logic br);
    logic busy_e, lu, hs, stl;
    logic pc_e, en_e, ff_e, xf_e;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_uses_hilo = uhl;
    ex_mem_read = mr; ex_rt = ert; ex_mdu_start = st; branch_taken_id = br;
    @(negedge clk);
    busy_e = !r && have_start && (cyc > last_start) && (cyc - last_start < L);
    lu  = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
    hs  = uhl && busy_e;
    stl = lu || hs;
    if (r)        {pc_e, en_e, ff_e, xf_e} = 4'b0011;
    else if (stl) {pc_e, en_e, ff_e, xf_e} = 4'b0001;
    else if (br)  {pc_e, en_e, ff_e, xf_e} = 4'b1110;
    else          {pc_e, en_e, ff_e, xf_e} = 4'b1100;
    check_val("pc_en", 32'(pc_en), 32'(pc_e));
    check_val("if_id_en", 32'(if_id_en), 32'(en_e));
    check_val("if_id_flush", 32'(if_id_flush), 32'(ff_e));
    check_val("id_ex_flush", 32'(id_ex_flush), 32'(xf_e));
    check_val("mdu_busy", 32'(mdu_busy), 32'(busy_e));
`ifdef HAZARD_CTRL_PERF_EN
    check_val("perf_stall", perf_stall_cnt, m_stall_cnt);
    check_val("perf_flush", perf_flush_cnt, m_flush_cnt);
    check_val("perf_hilo", perf_hilo_cnt, m_hilo_cnt);
`endif
    $display("cyc=%0d rst=%0b lu=%0b hs=%0b br=%0b st=%0b -> pc=%0b en=%0b iff=%0b ixf=%0b busy=%0b",
             cyc, r, lu, hs, br, st, pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy);
    @(posedge clk);
    if (r) begin
      have_start = 0;
`ifdef HAZARD_CTRL_PERF_EN
      m_stall_cnt = 0; m_flush_cnt = 0; m_hilo_cnt = 0;
`endif
    end else begin
      if (st) begin
        have_start = 1;
        last_start = cyc;
      end
`ifdef HAZARD_CTRL_PERF_EN
      if (stl) m_stall_cnt++;
      if (!stl && br) m_flush_cnt++;
      if (hs) m_hilo_cnt++;
`endif
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 2, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef HAZARD_CTRL_PERF_EN
    m_stall_cnt = 0; m_flush_cnt = 0; m_hilo_cnt = 0;
`endif
    @(posedge clk); #1;
    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Load-use on rs, then release.
    step(0, 8, 3, 1, 0, 1, 8, 0, 0);
    step(0, 8, 3, 1, 0, 0, 8, 0, 0);
    // Masking: $zero, rt unused, rt used.
    step(0, 0, 4, 1, 0, 1, 0, 0, 0);
    step(0, 5, 9, 0, 0, 1, 9, 0, 0);
    step(0, 5, 9, 1, 0, 1, 9, 0, 0);
    // Branch against a stall, then branch alone.
    step(0, 7, 2, 0, 0, 1, 7, 0, 1);
    step(0, 7, 2, 0, 0, 0, 7, 0, 1);
    // MDU op with mfhi held from the next cycle.
    step(0, 1, 2, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 2, 0, 1, 0, 0, 0, 0);
    // MDU restart at cycle 2 of an op.
    step(0, 1, 2, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 1, 2, 0, 0, 0, 0, 1, 0);
    idle(5);
    // Reset mid-busy, then check for clean recovery.
    step(0, 1, 2, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(1, 1, 2, 0, 1, 0, 0, 0, 1);
    step(1, 3, 2, 1, 0, 1, 3, 0, 0);
    step(0, 1, 2, 0, 1, 0, 0, 0, 0);
    idle(2);
    // Randomized cycles. Register fields are kept small so matches are common.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
